// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: sequencer state
// encoding and default sizing constants.
package fir_pkg;

  localparam int FIR_NUM_TAPS = 41;
  localparam int FIR_COEFF_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } fir_ld_state_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// Coefficient reload sequencer in front of fir_filter.
// It accepts NUM_TAPS coefficients from the host and writes one tap per cycle
// into the filter while its sample input is muted. It then feeds NUM_TAPS
// zeros to flush the delay line, and pulses done when the live samples return.
// Optional feature macro FIR_COEFF_LOADER_CHECKSUM_EN: checks the modulo-2^COEFF_W
// sum of the burst against load_checksum and flags a mismatch on chk_err.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int COEFF_W  = FIR_COEFF_W,
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_abort,
  input  logic [COEFF_W-1:0] load_checksum,
  input  logic               s_valid,
  input  logic [COEFF_W-1:0] s_data,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  samp_in,
  output logic [DATA_W-1:0]  fir_din,
  output logic               fir_coeff_update,
  output logic [SEL_W-1:0]   fir_coeff_sel,
  output logic [COEFF_W-1:0] fir_new_coeff,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               chk_err
);

  // The index of the last tap is also the terminal count of the flush counter.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_TAPS - 1);

  fir_ld_state_t        r_state;
  fir_ld_state_t        w_next_state;
  logic [SEL_W-1:0]     r_idx;
  logic [SEL_W-1:0]     r_flush_cnt;
  logic                 r_mute;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_aborted;
  logic                 r_update;
  logic [SEL_W-1:0]     r_sel;
  logic [COEFF_W-1:0]   r_coeff;

  logic                 w_start;
  logic                 w_abort;
  logic                 w_accept;
  logic                 w_last_hs;
  logic                 w_flush_end;

  // A start request counts only in IDLE. An abort counts only while a reload or flush is running.
  assign w_start     = (r_state == IDLE) && load_start;
  assign w_abort     = (r_state != IDLE) && load_abort;
  // A handshake in the same cycle as an abort is dropped.
  assign w_accept    = (r_state == LOAD) && s_valid && !w_abort;
  assign w_last_hs   = w_accept && (r_idx == LAST_IDX);
  assign w_flush_end = (r_state == FLUSH) && !w_abort && (r_flush_cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with <= so every flop samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_start)                 w_next_state = LOAD;
      LOAD:    if (w_abort)                 w_next_state = IDLE;
               else if (w_last_hs)          w_next_state = FLUSH;
      FLUSH:   if (w_abort || w_flush_end)  w_next_state = IDLE;
      default:                              w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs: the host may push coefficients only in LOAD.
  always_comb begin
    s_ready = 1'b0;
    if (r_state == LOAD) s_ready = 1'b1;
  end

  // Sequencer datapath: tap index, flush counter, mute/busy/done/aborted and the filter update port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_flush_cnt <= '0;
      r_mute      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_update    <= 1'b0;
      r_sel       <= '0;
      r_coeff     <= '0;
    end else begin
      r_update <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_idx     <= '0;
            r_mute    <= 1'b1;
            r_busy    <= 1'b1;
            r_aborted <= 1'b0;
          end
        end
        LOAD: begin
          if (w_abort) begin
            r_mute    <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (w_accept) begin
            r_sel    <= r_idx;
            r_coeff  <= s_data;
            r_update <= 1'b1;
            if (w_last_hs) r_flush_cnt <= '0;
            else           r_idx       <= r_idx + SEL_W'(1);
          end
        end
        FLUSH: begin
          if (w_abort) begin
            r_mute    <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (w_flush_end) begin
            r_mute <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + SEL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
  logic [COEFF_W-1:0] r_sum;
  logic [COEFF_W-1:0] r_chk_target;
  logic               r_chk_err;
  logic [COEFF_W-1:0] w_sum_next;

  assign w_sum_next = r_sum + s_data;

  // Running modulo-2^COEFF_W sum of accepted coefficients, compared on the final handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum        <= '0;
      r_chk_target <= '0;
      r_chk_err    <= 1'b0;
    end else if (w_start) begin
      r_sum        <= '0;
      r_chk_target <= load_checksum;
      r_chk_err    <= 1'b0;
    end else if (w_accept) begin
      r_sum <= w_sum_next;
      if (w_last_hs && (w_sum_next != r_chk_target)) r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  logic w_unused_checksum;
  assign w_unused_checksum = ^load_checksum;
  assign chk_err           = 1'b0;
`endif

  // The filter input is muted with a combinational mux on a registered select. This adds no latency when unmuted.
  assign fir_din          = r_mute ? '0 : samp_in;
  assign fir_coeff_update = r_update;
  assign fir_coeff_sel    = r_sel;
  assign fir_new_coeff    = r_coeff;
  assign busy             = r_busy;
  assign done             = r_done;
  assign aborted          = r_aborted;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed testbench for fir_coeff_loader.
// Covers reset values, continuous and stalled reloads, abort, ignored
// restarts, reset mid-load, and (with FIR_COEFF_LOADER_CHECKSUM_EN) the
// checksum flag.
module tb_fir_coeff_loader;

  localparam int NUM_TAPS = 41;
  localparam int COEFF_W  = 16;
  localparam int DATA_W   = 16;
  localparam int SEL_W    = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_start;
  logic               load_abort;
  logic [COEFF_W-1:0] load_checksum;
  logic               s_valid;
  logic [COEFF_W-1:0] s_data;
  logic               s_ready;
  logic [DATA_W-1:0]  samp_in;
  logic [DATA_W-1:0]  fir_din;
  logic               fir_coeff_update;
  logic [SEL_W-1:0]   fir_coeff_sel;
  logic [COEFF_W-1:0] fir_new_coeff;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               chk_err;

  int n_vec = 0;
  int n_err = 0;
  int coeff_mode = 0;

  fir_coeff_loader #(
    .NUM_TAPS (NUM_TAPS),
    .COEFF_W  (COEFF_W),
    .DATA_W   (DATA_W),
    .SEL_W    (SEL_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_abort       (load_abort),
    .load_checksum    (load_checksum),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .samp_in          (samp_in),
    .fir_din          (fir_din),
    .fir_coeff_update (fir_coeff_update),
    .fir_coeff_sel    (fir_coeff_sel),
    .fir_new_coeff    (fir_new_coeff),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .chk_err          (chk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COEFF_W-1:0] coeff_of(input int i);
    return (coeff_mode == 1) ? 16'hFFFF : COEFF_W'(i);
  endfunction

  // Run a reload starting now. The coefficient for tap i is coeff_of(i).
  // valid_every=1: s_valid is held high. valid_every=2: s_valid is high on odd cycles only.
  // abort_idx>=0: assert load_abort after that many handshakes.
  // restart_at>0: pulse load_start on that cycle while busy.
  // done_at is the cycle offset from load_start, or -1 if done never arrives.
  task automatic run_load(input int valid_every, input int abort_idx, input int restart_at,
                          input logic exp_chk, output int n_upd, output int done_at);
    int  hs_cnt;
    int  last_hs;
    bit  prev_hs;
    bit  in_load;
    bit  hs;
    bit  ended;
    hs_cnt = 0; last_hs = -1; prev_hs = 1'b0; in_load = 1'b1; ended = 1'b0;
    n_upd = 0; done_at = -1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("aborted_clr_on_start", aborted, 1'b0);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      check("upd_follows_hs", fir_coeff_update, prev_hs);
      if (fir_coeff_update) n_upd++;
      if (prev_hs) begin
        check("sel", fir_coeff_sel, hs_cnt - 1);
        check("coeff", fir_new_coeff, coeff_of(hs_cnt - 1));
      end
      if (last_hs >= 0 && cyc == last_hs + NUM_TAPS + 1) begin
        check("done", done, 1'b1);
        check("busy_off_at_done", busy, 1'b0);
        check("din_live_at_done", fir_din, samp_in);
        check("chk_err", chk_err, exp_chk);
        done_at = cyc;
        tick();
        check("done_one_cycle", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        ended = 1'b1;
        break;
      end
      check("done_early", done, 1'b0);
      check("busy", busy, 1'b1);
      check("din_muted", fir_din, 0);
      check("s_ready", s_ready, in_load);
      s_valid    = (valid_every == 1) || (cyc % 2 == 1);
      s_data     = coeff_of(hs_cnt);
      load_abort = in_load && (hs_cnt == abort_idx);
      load_start = (cyc == restart_at);
      hs         = s_valid && in_load && !load_abort;
      if (load_abort) begin
        tick();
        load_abort = 1'b0;
        s_valid    = 1'b0;
        load_start = 1'b0;
        check("abort_drops_update", fir_coeff_update, 1'b0);
        check("aborted_set", aborted, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_unmute", fir_din, samp_in);
        check("abort_ready", s_ready, 1'b0);
        for (int k = 0; k < NUM_TAPS + 5; k++) begin
          tick();
          check("abort_no_done", done, 1'b0);
        end
        ended = 1'b1;
        break;
      end
      prev_hs = hs;
      if (hs) begin
        hs_cnt++;
        if (hs_cnt == NUM_TAPS) begin
          in_load = 1'b0;
          last_hs = cyc;
        end
      end
      tick();
    end
    s_valid    = 1'b0;
    load_start = 1'b0;
    if (!ended) check("reload_timeout", 0, 1);
  endtask

  initial begin
    int n_upd;
    int done_at;
    logic exp_bad;
    reset = 1'b1; load_start = 1'b0; load_abort = 1'b0; load_checksum = '0;
    s_valid = 1'b0; s_data = '0; samp_in = 16'hFFFF;
    repeat (3) tick();
    reset = 1'b0;

    // Reset values.
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_update", fir_coeff_update, 1'b0);
    check("rst_sel", fir_coeff_sel, 0);
    check("rst_coeff", fir_new_coeff, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_aborted", aborted, 1'b0);
    check("rst_chk_err", chk_err, 1'b0);
    check("rst_din", fir_din, 16'hFFFF);

    // An abort in IDLE is ignored.
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check("idle_abort_ignored", aborted, 1'b0);
    check("idle_abort_busy", busy, 1'b0);

    // Continuous reload with coefficients 0..40: done arrives 83 cycles after load_start.
    run_load(1, -1, 0, 1'b0, n_upd, done_at);
    check("cont_updates", n_upd, 41);
    check("cont_done_at", done_at, 83);

    // The host stalls every other cycle: last handshake at cycle 81, so done arrives at 81+42.
    samp_in = 16'h1234;
    run_load(2, -1, 0, 1'b0, n_upd, done_at);
    check("stall_updates", n_upd, 41);
    check("stall_done_at", done_at, 123);

    // Abort after 10 handshakes.
    run_load(1, 10, 0, 1'b0, n_upd, done_at);
    check("abort_updates", n_upd, 10);
    check("abort_no_done_at", done_at, -1);

    // load_start while busy is ignored. The sequence and done timing are unchanged, and aborted is cleared.
    samp_in = 16'hA5C3;
    run_load(1, -1, 20, 1'b0, n_upd, done_at);
    check("restart_updates", n_upd, 41);
    check("restart_done_at", done_at, 83);

    // Start and abort in the same IDLE cycle: start wins.
    load_start = 1'b1;
    load_abort = 1'b1;
    tick();
    load_start = 1'b0;
    load_abort = 1'b0;
    check("start_wins_busy", busy, 1'b1);
    check("start_wins_aborted", aborted, 1'b0);
    check("start_wins_ready", s_ready, 1'b1);

    // Reset mid-load returns to IDLE with no done and no aborted.
    s_valid = 1'b1;
    s_data  = 16'h0007;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    s_valid = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_aborted", aborted, 1'b0);
    check("midrst_ready", s_ready, 1'b0);
    check("midrst_update", fir_coeff_update, 1'b0);
    check("midrst_din", fir_din, 16'hA5C3);

    // Checksum: 41 * 0xFFFF mod 2^16 = 0xFFD7.
    coeff_mode    = 1;
    load_checksum = 16'hFFD7;
    run_load(1, -1, 0, 1'b0, n_upd, done_at);
    check("cs_good_done_at", done_at, 83);
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    load_checksum = 16'h0000;
    run_load(1, -1, 0, exp_bad, n_upd, done_at);
    check("cs_bad_done_at", done_at, 83);
    check("cs_bad_sticky", chk_err, exp_bad);
    load_checksum = 16'hFFD7;
    run_load(1, -1, 0, 1'b0, n_upd, done_at);
    check("cs_clear_done_at", done_at, 83);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Sequencer that sits in front of `fir_filter` and owns its coefficient-update port and sample input. It accepts a burst of NUM_TAPS coefficients from a host over a valid/ready stream. It writes them into the filter one tap per cycle and mutes the filter input during the reload. It then flushes the filter delay line with zeros before handing the sample path back.

## Interface
Parameters:
- NUM_TAPS, 41, number of filter taps / coefficients per load
- COEFF_W, 16, coefficient width
- DATA_W, 16, sample width
- SEL_W, 6, width of tap index; must satisfy 2**SEL_W >= NUM_TAPS

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle request to begin a reload; ignored unless idle
- load_abort  in  1  abandon the reload in progress
- load_checksum  in  COEFF_W  expected modulo-2^COEFF_W sum of the burst; sampled with load_start
- s_valid  in  1  host coefficient valid
- s_data  in  COEFF_W  host coefficient
- s_ready  out  1  loader accepts a coefficient
- samp_in  in  DATA_W  live sample stream
- fir_din  out  DATA_W  to `fir_filter.din`
- fir_coeff_update  out  1  to `fir_filter.coeff_update`
- fir_coeff_sel  out  SEL_W  to `fir_filter.coeff_sel`
- fir_new_coeff  out  COEFF_W  to `fir_filter.new_coeff`
- busy  out  1  reload or flush in progress
- done  out  1  one-cycle pulse when the filter is back in service
- aborted  out  1  sticky; set by abort, cleared by next accepted load_start
- chk_err  out  1  sticky checksum mismatch; see Configuration

## Operation
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - s_ready=0, mute=0.
  - load_start -> LOAD; idx<=0, mute<=1, busy<=1, aborted<=0, chk_err<=0, sum<=0.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready handshake registers fir_coeff_sel<=idx, fir_new_coeff<=s_data, fir_coeff_update<=1, then idx<=idx+1.
  - No handshake: fir_coeff_update<=0. Host stalls (s_valid=0) are allowed indefinitely.
  - Handshake at idx==NUM_TAPS-1 -> FLUSH with flush_cnt<=0.
- FLUSH:
  - s_ready=0, mute stays 1.
  - flush_cnt counts NUM_TAPS cycles.
  - At flush_cnt==NUM_TAPS-1 -> IDLE, mute<=0, busy<=0, done<=1 for one cycle.
- fir_din = mute ? 0 : samp_in. This is a combinational mux on a registered select, so there is no extra sample latency when unmuted.
- load_abort in LOAD or FLUSH:
  - -> IDLE next cycle; aborted<=1, busy<=0, mute<=0.
  - No done pulse.
  - Any coefficient handshake in the same cycle is dropped: no update is issued for it.
  - Coefficients already written stay in the filter.
- load_abort in IDLE is ignored.
- load_start while busy is ignored; it is not queued.
- load_start and load_abort in the same IDLE cycle: start wins.
- idx never wraps. Handshakes past NUM_TAPS cannot occur because s_ready drops on leaving LOAD.

## Timing
- Reset values: s_ready=0, fir_din=samp_in (mute=0), fir_coeff_update=0, fir_coeff_sel=0, fir_new_coeff=0, busy=0, done=0, aborted=0, chk_err=0. State=IDLE.
- Reset mid-load returns to IDLE immediately. No done, no aborted.
- load_start at cycle T:
  - busy=1, mute=1, and s_ready=1 from T+1.
- Handshake at cycle H:
  - fir_coeff_update is high during H+1 only, with sel/coeff stable.
- Minimum reload: first handshake T+1, last T+NUM_TAPS, FLUSH T+NUM_TAPS+1 .. T+2*NUM_TAPS. done pulses at T+2*NUM_TAPS+1, and mute=0 that same cycle.
- Back-to-back handshakes produce back-to-back update pulses.

## Configuration
- Macro: FIR_COEFF_LOADER_CHECKSUM_EN.
- Defined:
  - load_checksum is captured at load_start.
  - Each accepted coefficient is added modulo 2^COEFF_W into sum.
  - On the final handshake, if sum+s_data != captured checksum, chk_err<=1 (sticky).
  - The flush and done still occur; the error is advisory.
- Not defined:
  - No sum register.
  - load_checksum is unused.
  - chk_err is tied 0.

## Structure
- Shared package `fir_pkg` holds:
  - the state enum `fir_ld_state_t` (IDLE/LOAD/FLUSH);
  - default constants FIR_NUM_TAPS=41 and FIR_COEFF_W=16.
- Single module, no sub-module. The checksum accumulator is an ifdef'd block inside it.

## Test plan
- Reset, then load_start with s_valid held high and coefficients 0..40 -> 41 consecutive fir_coeff_update pulses, with sel=i and coeff=i. done arrives exactly 83 cycles after load_start, and busy=0 afterwards.
- samp_in=16'hFFFF throughout a reload -> fir_din=0 from load_start+1 through the last FLUSH cycle, then 16'hFFFF from the done cycle on.
- Host drops s_valid every other cycle -> update pulses only follow handshakes, sel is still 0..40 in order, and there are no gaps in sel.
- load_abort at idx=10 -> exactly 10 update pulses, aborted=1, no done, mute released the next cycle. The next load_start clears aborted.
- load_start while busy -> ignored, with no change to idx or to the done timing.
- With FIR_COEFF_LOADER_CHECKSUM_EN: 41 coefficients of 16'hFFFF with load_checksum=16'hFFD7 -> chk_err=0. With load_checksum=16'h0000 -> chk_err=1 after the final update, and done still pulses.
